// File: rtl/plru_victim_array.sv
// plru_victim_array
// Tree pseudo-LRU replacement engine for the set-associative caches.
// Each set keeps WAYS-1 tree bits. Node n is stored at bit n-1, with node 1
// as the root and nodes 2n and 2n+1 as its children. A tree bit of 0 steers
// the victim into the lower (left) half and 1 into the upper (right) half.
// An invalid way always wins over the tree choice.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   flush            : pulse, restarts the clearing sweep from set 0
//   busy             : sweep in progress; lookups and touches are ignored
//   req_valid        : victim lookup request
//   req_index        : set to look up
//   req_valid_ways   : per-way valid bits of that set (bit i = way i)
//   victim_valid     : one-cycle strobe, one cycle after an accepted request
//   victim_way       : one-hot victim; holds its value between strobes
//   touch_valid      : hit/refill update
//   touch_index      : set touched
//   touch_way        : one-hot way touched; zero or multi-hot is ignored
module plru_victim_array #(
    parameter int WAYS = 4,
    parameter int SETS = 128,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             busy,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_index,
    input  logic [WAYS-1:0]  req_valid_ways,
    output logic             victim_valid,
    output logic [WAYS-1:0]  victim_way,
    input  logic             touch_valid,
    input  logic [IDX_W-1:0] touch_index,
    input  logic [WAYS-1:0]  touch_way
);

    localparam int LVL   = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    typedef enum logic {SWEEP, RUN} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    // Per-set tree bits. This is an asynchronous-read array because the
    // lookup, the forwarding and the tree walk all fit in the single stage
    // ahead of the victim flop.
    logic [NODES-1:0] tree_mem [SETS];

    logic             touch_onehot;
    logic [LVL-1:0]   touch_idx;
    logic [NODES-1:0] path_mask;
    logic [NODES-1:0] path_val;
    logic [LVL:0]     t_node;
    logic             t_bit;
    logic [NODES-1:0] touch_cur;
    logic [NODES-1:0] touch_new;
    logic             touch_en;
    logic             req_en;

    logic [NODES-1:0] req_tree;
    logic [LVL:0]     w_node;
    logic             w_bit;
    logic [LVL-1:0]   tree_idx;
    logic             inv_found;
    logic [LVL-1:0]   inv_idx;
    logic [LVL-1:0]   victim_idx;
    logic [WAYS-1:0]  victim_next;

    logic             victim_valid_reg;
    logic [WAYS-1:0]  victim_way_reg;

    // ---------------- sweep / run control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SWEEP;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (flush) begin
            state_next = SWEEP;
            ptr_next   = '0;
        end else if (state_reg == SWEEP) begin
            if (ptr_reg == IDX_W'(SETS - 1)) begin
                state_next = RUN;
                ptr_next   = '0;
            end else begin
                ptr_next = ptr_reg + IDX_W'(1);
            end
        end
    end

    assign busy = (state_reg == SWEEP);

    // A flush cycle drops both the lookup and the touch. The sweep that
    // follows clears the state anyway.
    assign touch_en = (state_reg == RUN) && touch_valid && touch_onehot && !flush;
    assign req_en   = (state_reg == RUN) && req_valid && !flush;

    // ---------------- touch: path update ----------------
    always_comb begin
        touch_onehot = (touch_way != '0) && ((touch_way & (touch_way - WAYS'(1))) == '0);
        touch_idx    = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (touch_way[i]) begin
                touch_idx = LVL'(i);
            end
        end
    end

    // Walk the root-to-leaf path of the touched way. Each node on the path
    // is set to point away from the way: a left-subtree way writes 1 and a
    // right-subtree way writes 0.
    always_comb begin
        path_mask = '0;
        path_val  = '0;
        t_node    = (LVL + 1)'(1);
        t_bit     = 1'b0;
        for (int l = 0; l < LVL; l++) begin
            t_bit                         = touch_idx[LVL-1-l];
            path_mask[int'(t_node) - 1]   = 1'b1;
            path_val[int'(t_node) - 1]    = ~t_bit;
            t_node                        = {t_node[LVL-1:0], t_bit};
        end
    end

    assign touch_cur = tree_mem[touch_index];
    assign touch_new = (touch_cur & ~path_mask) | (path_val & path_mask);

    always_ff @(posedge clk) begin
        if (state_reg == SWEEP) begin
            tree_mem[ptr_reg] <= '0;
        end else if (touch_en) begin
            tree_mem[touch_index] <= touch_new;
        end
    end

    // ---------------- lookup: victim choice ----------------
    // A same-cycle touch to the requested set is forwarded, so the victim
    // reflects the post-touch state.
    assign req_tree = (touch_en && (touch_index == req_index)) ? touch_new
                                                               : tree_mem[req_index];

    always_comb begin
        w_node = (LVL + 1)'(1);
        w_bit  = 1'b0;
        for (int l = 0; l < LVL; l++) begin
            w_bit  = req_tree[int'(w_node) - 1];
            w_node = {w_node[LVL-1:0], w_bit};
        end
        // The leaf number minus WAYS is the way index, which is the low bits.
        tree_idx = w_node[LVL-1:0];
    end

    // Lowest invalid way. The loop scans downwards, so the last hit is the lowest.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!req_valid_ways[i]) begin
                inv_found = 1'b1;
                inv_idx   = LVL'(i);
            end
        end
        victim_idx  = inv_found ? inv_idx : tree_idx;
        victim_next = WAYS'(1) << victim_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            victim_valid_reg <= 1'b0;
            victim_way_reg   <= '0;
        end else begin
            victim_valid_reg <= req_en;
            if (req_en) begin
                victim_way_reg <= victim_next;
            end
        end
    end

    assign victim_valid = victim_valid_reg;
    assign victim_way   = victim_way_reg;

endmodule

// File: tb/tb_plru_victim_array.sv
// tb_plru_victim_array
// Directed bench for plru_victim_array. Instance A is 4-way with 128 sets.
// Instance B is 2-way with 4 sets. The stimulus queues the expected victim
// for each request it issues. Per-instance monitors pop the queue and compare
// whenever victim_valid is seen. A strobe with an empty queue is an error.
module tb_plru_victim_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: 4 ways, 128 sets ----------------
    logic       a_rst, a_flush, a_busy;
    logic       a_req_valid;
    logic [6:0] a_req_index;
    logic [3:0] a_req_valid_ways;
    logic       a_victim_valid;
    logic [3:0] a_victim_way;
    logic       a_touch_valid;
    logic [6:0] a_touch_index;
    logic [3:0] a_touch_way;

    plru_victim_array #(.WAYS(4), .SETS(128)) u_a (
        .clk            (clk),
        .rst            (a_rst),
        .flush          (a_flush),
        .busy           (a_busy),
        .req_valid      (a_req_valid),
        .req_index      (a_req_index),
        .req_valid_ways (a_req_valid_ways),
        .victim_valid   (a_victim_valid),
        .victim_way     (a_victim_way),
        .touch_valid    (a_touch_valid),
        .touch_index    (a_touch_index),
        .touch_way      (a_touch_way)
    );

    // ---------------- instance B: 2 ways, 4 sets ----------------
    logic       b_rst, b_flush, b_busy;
    logic       b_req_valid;
    logic [1:0] b_req_index;
    logic [1:0] b_req_valid_ways;
    logic       b_victim_valid;
    logic [1:0] b_victim_way;
    logic       b_touch_valid;
    logic [1:0] b_touch_index;
    logic [1:0] b_touch_way;

    plru_victim_array #(.WAYS(2), .SETS(4)) u_b (
        .clk            (clk),
        .rst            (b_rst),
        .flush          (b_flush),
        .busy           (b_busy),
        .req_valid      (b_req_valid),
        .req_index      (b_req_index),
        .req_valid_ways (b_req_valid_ways),
        .victim_valid   (b_victim_valid),
        .victim_way     (b_victim_way),
        .touch_valid    (b_touch_valid),
        .touch_index    (b_touch_index),
        .touch_way      (b_touch_way)
    );

    logic [3:0] q_a [$];
    logic [1:0] q_b [$];
    logic [3:0] e_a;
    logic [1:0] e_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        #1;
        if (a_victim_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_victim actual=%b required=no strobe", a_victim_way);
            end else begin
                e_a = q_a.pop_front();
                chk("a_victim", 32'(a_victim_way), 32'(e_a));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (b_victim_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_victim actual=%b required=no strobe", b_victim_way);
            end else begin
                e_b = q_b.pop_front();
                chk("b_victim", 32'(b_victim_way), 32'(e_b));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_drive(input bit rv, input logic [6:0] ri, input logic [3:0] rw,
                           input logic [3:0] exp, input bit tv, input logic [6:0] ti,
                           input logic [3:0] tw);
        @(negedge clk);
        a_req_valid      = rv;
        a_req_index      = ri;
        a_req_valid_ways = rw;
        a_touch_valid    = tv;
        a_touch_index    = ti;
        a_touch_way      = tw;
        if (rv) q_a.push_back(exp);
    endtask

    task automatic a_look(input logic [6:0] ri, input logic [3:0] rw, input logic [3:0] exp);
        a_drive(1'b1, ri, rw, exp, 1'b0, 7'd0, 4'd0);
    endtask

    task automatic a_touch(input logic [6:0] ti, input logic [3:0] tw);
        a_drive(1'b0, 7'd0, 4'hf, 4'd0, 1'b1, ti, tw);
    endtask

    task automatic a_idle();
        @(negedge clk);
        a_req_valid   = 1'b0;
        a_touch_valid = 1'b0;
        a_flush       = 1'b0;
    endtask

    // Called at the negedge where rst/flush has just been dropped. It counts
    // the cycles busy stays high and fires requests that must all be ignored.
    task automatic a_sweep_len(output int n);
        n = 0;
        while (a_busy === 1'b1 && n < 1000) begin
            a_req_valid      = 1'b1;
            a_req_index      = 7'(n);
            a_req_valid_ways = 4'hf;
            n++;
            @(negedge clk);
        end
        a_req_valid = 1'b0;
    endtask

    task automatic b_drive(input bit rv, input logic [1:0] ri, input logic [1:0] rw,
                           input logic [1:0] exp, input bit tv, input logic [1:0] ti,
                           input logic [1:0] tw);
        @(negedge clk);
        b_req_valid      = rv;
        b_req_index      = ri;
        b_req_valid_ways = rw;
        b_touch_valid    = tv;
        b_touch_index    = ti;
        b_touch_way      = tw;
        if (rv) q_b.push_back(exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        a_rst = 1'b1; a_flush = 1'b0; a_req_valid = 1'b0; a_req_index = '0;
        a_req_valid_ways = '1; a_touch_valid = 1'b0; a_touch_index = '0; a_touch_way = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_req_valid = 1'b0; b_req_index = '0;
        b_req_valid_ways = '1; b_touch_valid = 1'b0; b_touch_index = '0; b_touch_way = '0;

        repeat (3) @(negedge clk);
        chk("a_reset_busy", 32'(a_busy), 32'd1);
        chk("a_reset_victim_valid", 32'(a_victim_valid), 32'd0);
        chk("a_reset_victim_way", 32'(a_victim_way), 32'd0);

        // Initial sweep after reset. Requests issued meanwhile must be ignored.
        a_rst = 1'b0;
        a_sweep_len(n);
        chk("a_sweep_cycles", 32'(n), 32'd128);

        // Every set is all-zero, so an all-valid lookup picks way 0.
        for (int s = 0; s < 128; s++) a_look(7'(s), 4'hf, 4'b0001);

        // Set 5: touch ways 0..3, then way 0 again.
        a_touch(7'd5, 4'b0001);
        a_touch(7'd5, 4'b0010);
        a_touch(7'd5, 4'b0100);
        a_touch(7'd5, 4'b1000);
        a_look(7'd5, 4'hf, 4'b0001);
        a_touch(7'd5, 4'b0001);
        a_look(7'd5, 4'hf, 4'b0100);
        a_look(7'd5, 4'b1011, 4'b0100);
        a_look(7'd5, 4'b0000, 4'b0001);

        // Set 6: after a touch of way 2 the tree points at way 0, but invalid ways win.
        a_touch(7'd6, 4'b0100);
        a_look(7'd6, 4'hf, 4'b0001);
        a_look(7'd6, 4'b1011, 4'b0100);
        a_look(7'd6, 4'b0000, 4'b0001);
        a_look(7'd6, 4'b0111, 4'b1000);

        // Set 9: a touch of way 0 in the same cycle as the lookup is forwarded.
        a_drive(1'b1, 7'd9, 4'hf, 4'b0100, 1'b1, 7'd9, 4'b0001);
        a_look(7'd9, 4'hf, 4'b0100);
        // A multi-hot or zero touch leaves the state unchanged.
        a_touch(7'd9, 4'b0011);
        a_look(7'd9, 4'hf, 4'b0100);
        a_touch(7'd9, 4'b0000);
        a_look(7'd9, 4'hf, 4'b0100);

        // A touch and a lookup to different sets in the same cycle are independent.
        a_drive(1'b1, 7'd11, 4'hf, 4'b0001, 1'b1, 7'd10, 4'b0001);
        a_look(7'd10, 4'hf, 4'b0100);
        a_idle();

        // Flush in RUN together with a request: the request is dropped.
        @(negedge clk);
        a_flush = 1'b1; a_req_valid = 1'b1; a_req_index = 7'd5; a_req_valid_ways = 4'hf;
        @(negedge clk);
        a_flush = 1'b0; a_req_valid = 1'b0;
        chk("a_flush_run_busy", 32'(a_busy), 32'd1);
        a_sweep_len(n);
        chk("a_flush_run_sweep_cycles", 32'(n), 32'd128);
        a_look(7'd5, 4'hf, 4'b0001);
        a_look(7'd6, 4'hf, 4'b0001);
        a_look(7'd9, 4'hf, 4'b0001);
        a_look(7'd10, 4'hf, 4'b0001);
        a_idle();

        // Reset, then flush once the sweep pointer has reached 40.
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("a_midsweep_busy", 32'(a_busy), 32'd1);
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        a_sweep_len(n);
        chk("a_midsweep_restart_cycles", 32'(n), 32'd128);
        a_look(7'd0, 4'hf, 4'b0001);
        a_look(7'd127, 4'hf, 4'b0001);
        a_idle();

        // 2-way regression.
        @(negedge clk);
        b_rst = 1'b0;
        n = 0;
        while (b_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b_sweep_cycles", 32'(n), 32'd4);
        b_drive(1'b1, 2'd0, 2'b00, 2'b01, 1'b0, 2'd0, 2'b00);
        b_drive(1'b1, 2'd0, 2'b10, 2'b01, 1'b0, 2'd0, 2'b00);
        b_drive(1'b1, 2'd0, 2'b01, 2'b10, 1'b0, 2'd0, 2'b00);
        b_drive(1'b1, 2'd2, 2'b11, 2'b01, 1'b0, 2'd0, 2'b00);
        b_drive(1'b0, 2'd0, 2'b11, 2'b00, 1'b1, 2'd1, 2'b01);
        b_drive(1'b1, 2'd1, 2'b11, 2'b10, 1'b0, 2'd0, 2'b00);
        b_drive(1'b0, 2'd0, 2'b11, 2'b00, 1'b1, 2'd1, 2'b10);
        b_drive(1'b1, 2'd1, 2'b11, 2'b01, 1'b0, 2'd0, 2'b00);
        @(negedge clk);
        b_req_valid   = 1'b0;
        b_touch_valid = 1'b0;

        repeat (4) @(negedge clk);
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
